// File: rtl/buffer_bank_scheduler.sv
`timescale 1ns/1ps
// buffer_bank_scheduler
// Sequences a bank of NUM_BUF single-entry holding buffers as one in-order
// queue. Accepted words are steered into the next free buffer with a one-hot
// select and a shared read-inhibit. Stored words are drained in order through
// an output mux under a valid/ready handshake.
//
// Ports:
//   Clk, Rst        clock, asynchronous active-high reset
//   start           IDLE -> RUN request
//   flush           stop accepting, drain remaining words, then clear
//   abort           discard everything, clear on the next edge
//   inValid/inReady producer handshake (data goes straight into the buffers)
//   outValid/outReady/outData  consumer handshake, oldest stored word
//   bufData, bufFull  buffer outputs and full flags from the bank
//   bufSel, bufRD, bufCLR, bufEN  bank control strobes
//   count           number of stored words (0..NUM_BUF)
//   err             sticky consistency error (cleared by reset or abort)
module buffer_bank_scheduler #(
  parameter int unsigned NUM_BUF = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PTR_W   = $clog2(NUM_BUF)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      start,
  input  logic                      flush,
  input  logic                      abort,
  input  logic                      inValid,
  output logic                      inReady,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [DATA_W-1:0]         outData,
  input  logic [NUM_BUF*DATA_W-1:0] bufData,
  input  logic [NUM_BUF-1:0]        bufFull,
  output logic [NUM_BUF-1:0]        bufSel,
  output logic                      bufRD,
  output logic [NUM_BUF-1:0]        bufCLR,
  output logic                      bufEN,
  output logic [PTR_W:0]            count,
  output logic                      err
);

  typedef enum logic [1:0] {CLEAR, IDLE, RUN, DRAIN} state_t;

  localparam logic [PTR_W:0] FULL_CNT = NUM_BUF[PTR_W:0];

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             active;
  logic             push;
  logic             pop;
  logic             err_set;
  logic [DATA_W-1:0] head_word;
  logic [PTR_W:0]   next_count;

  // Head-of-queue mux over the packed buffer outputs.
  always_comb begin
    head_word = '0;
    for (int unsigned i = 0; i < NUM_BUF; i++) begin
      if (rd_ptr == PTR_W'(i)) head_word = bufData[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    active   = (state == RUN) || (state == DRAIN);
    inReady  = (state == RUN) && (count < FULL_CNT);
    outValid = active && (count != '0);
    push     = inValid && inReady;
    pop      = outValid && outReady;
    outData  = outValid ? head_word : '0;
    bufSel   = push ? (NUM_BUF'(1) << wr_ptr) : '0;
    bufRD    = ~push;
    bufEN    = active;
    if (state == CLEAR) bufCLR = '1;
    else if (pop)       bufCLR = NUM_BUF'(1) << rd_ptr;
    else                bufCLR = '0;
    // A stored head must be flagged full; a write target must be empty.
    err_set  = (outValid && !bufFull[rd_ptr]) || (push && bufFull[wr_ptr]);
    case ({push, pop})
      2'b10:   next_count = count + 1'b1;
      2'b01:   next_count = count - 1'b1;
      default: next_count = count;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= CLEAR;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else if (abort) begin
      state  <= CLEAR;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (err_set) err <= 1'b1;
      case (state)
        CLEAR: begin
          state  <= IDLE;
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN, DRAIN: begin
          if (push) wr_ptr <= wr_ptr + 1'b1;
          if (pop)  rd_ptr <= rd_ptr + 1'b1;
          count <= next_count;
          // Leave DRAIN as soon as the edge that removes the last word occurs.
          if (state == RUN && flush)                  state <= DRAIN;
          else if (state == DRAIN && next_count == '0) state <= CLEAR;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_bank_scheduler.sv
`timescale 1ns/1ps
module tb_buffer_bank_scheduler;
  localparam int N = 4;
  localparam int W = 16;

  logic Clk = 1'b0;
  logic Rst;
  logic start, flush, abort, inValid, outReady;
  logic inReady, outValid, bufRD, bufEN, err;
  logic [W-1:0] outData;
  logic [N*W-1:0] bufData;
  logic [N-1:0] bufFull, bufSel, bufCLR;
  logic [2:0] count;

  always #5 Clk = ~Clk;

  buffer_bank_scheduler #(.NUM_BUF(N), .DATA_W(W)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .flush(flush), .abort(abort),
    .inValid(inValid), .inReady(inReady), .outValid(outValid),
    .outReady(outReady), .outData(outData), .bufData(bufData),
    .bufFull(bufFull), .bufSel(bufSel), .bufRD(bufRD), .bufCLR(bufCLR),
    .bufEN(bufEN), .count(count), .err(err)
  );

  // Behavioural holding-buffer bank driven by the scheduler strobes.
  logic [W-1:0] mem [N];
  logic [N-1:0] full;
  logic [N-1:0] kill;
  logic [W-1:0] in_word;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      full <= '0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bufCLR[i]) full[i] <= 1'b0;
        else if (bufEN && bufSel[i] && !bufRD) begin
          mem[i]  <= in_word;
          full[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bufFull = full & ~kill;
    for (int i = 0; i < N; i++) bufData[i*W +: W] = mem[i];
  end

  // Reference model: queue contents plus write/read slot counters.
  localparam int M_CLR = 0, M_IDLE = 1, M_RUN = 2, M_DRAIN = 3;
  int m_st;
  logic [W-1:0] q[$];
  int wp, rp;
  bit m_err;
  bit e_push, e_pop, e_eset;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_CLR;
    q.delete();
    wp = 0;
    rp = 0;
    m_err = 0;
  endtask

  task automatic drive(input bit s, input bit f, input bit a, input bit iv,
                       input bit orr, input logic [W-1:0] d);
    bit e_act, e_ir, e_ov;
    logic [W-1:0] e_od;
    logic [N-1:0] e_sel, e_clr;
    start = s; flush = f; abort = a; inValid = iv; outReady = orr; in_word = d;
    #4;
    e_act  = (m_st == M_RUN) || (m_st == M_DRAIN);
    e_ir   = (m_st == M_RUN) && (q.size() < N);
    e_ov   = e_act && (q.size() > 0);
    e_od   = e_ov ? q[0] : '0;
    e_push = iv && e_ir;
    e_pop  = e_ov && orr;
    e_sel  = e_push ? N'(1 << wp) : '0;
    e_clr  = (m_st == M_CLR) ? '1 : (e_pop ? N'(1 << rp) : '0);
    e_eset = (e_ov && !bufFull[rp]) || (e_push && bufFull[wp]);
    check("inReady",  32'(inReady),  32'(e_ir));
    check("outValid", 32'(outValid), 32'(e_ov));
    check("outData",  32'(outData),  32'(e_od));
    check("bufSel",   32'(bufSel),   32'(e_sel));
    check("bufRD",    32'(bufRD),    32'(!e_push));
    check("bufCLR",   32'(bufCLR),   32'(e_clr));
    check("bufEN",    32'(bufEN),    32'(e_act));
    check("count",    32'(count),    32'(q.size()));
    check("err",      32'(err),      32'(m_err));
  endtask

  task automatic advance();
    @(posedge Clk);
    if (abort) model_reset();
    else begin
      case (m_st)
        M_CLR: begin m_st = M_IDLE; wp = 0; rp = 0; end
        M_IDLE: if (start) m_st = M_RUN;
        default: begin
          if (e_eset) m_err = 1;
          if (e_pop) begin void'(q.pop_front()); rp = (rp + 1) % N; end
          if (e_push) begin q.push_back(in_word); wp = (wp + 1) % N; end
          if (m_st == M_RUN && flush) m_st = M_DRAIN;
          else if (m_st == M_DRAIN && q.size() == 0) begin
            m_st = M_CLR; wp = 0; rp = 0;
          end
        end
      endcase
    end
    #1;
  endtask

  task automatic cycle(input bit s, input bit f, input bit a, input bit iv,
                       input bit orr, input logic [W-1:0] d);
    drive(s, f, a, iv, orr, d);
    advance();
  endtask

  typedef struct {
    bit s, f, a, iv, orr;
    logic [W-1:0] d;
    bit ir, ov;
    logic [W-1:0] od;
    int cnt;
    logic [N-1:0] clr;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{0,0,0,0,0,16'h0000, 0,0,16'h0000,0,4'hF};
    tbl[1]  = '{1,0,0,0,0,16'h0000, 0,0,16'h0000,0,4'h0};
    tbl[2]  = '{0,0,0,1,0,16'h1111, 1,0,16'h0000,0,4'h0};
    tbl[3]  = '{0,0,0,1,0,16'h2222, 1,1,16'h1111,1,4'h0};
    tbl[4]  = '{0,0,0,1,0,16'h3333, 1,1,16'h1111,2,4'h0};
    tbl[5]  = '{0,0,0,0,1,16'h0000, 1,1,16'h1111,3,4'h1};
    tbl[6]  = '{0,0,0,0,1,16'h0000, 1,1,16'h2222,2,4'h2};
    tbl[7]  = '{0,0,0,0,1,16'h0000, 1,1,16'h3333,1,4'h4};
    tbl[8]  = '{0,0,0,0,0,16'h0000, 1,0,16'h0000,0,4'h0};
    tbl[9]  = '{0,0,0,1,0,16'hAAAA, 1,0,16'h0000,0,4'h0};
    tbl[10] = '{0,0,0,1,0,16'hBBBB, 1,1,16'hAAAA,1,4'h0};
    tbl[11] = '{0,1,0,0,0,16'h0000, 1,1,16'hAAAA,2,4'h0};
    tbl[12] = '{0,0,0,0,1,16'h0000, 0,1,16'hAAAA,2,4'h8};
    tbl[13] = '{0,0,0,0,1,16'h0000, 0,1,16'hBBBB,1,4'h1};
    tbl[14] = '{0,0,0,0,0,16'h0000, 0,0,16'h0000,0,4'hF};
    tbl[15] = '{0,0,0,0,0,16'h0000, 0,0,16'h0000,0,4'h0};

    kill = '0;
    Rst = 1'b1;
    start = 0; flush = 0; abort = 0; inValid = 0; outReady = 0; in_word = '0;
    #12;
    check("rst_clr",   32'(bufCLR),  32'hF);
    check("rst_en",    32'(bufEN),   32'h0);
    check("rst_ready", 32'(inReady), 32'h0);
    check("rst_count", 32'(count),   32'h0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    model_reset();

    // Directed table: ordered push/pop, then flush with two words.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].s, tbl[i].f, tbl[i].a, tbl[i].iv, tbl[i].orr, tbl[i].d);
      check("tbl_ir",  32'(inReady),  32'(tbl[i].ir));
      check("tbl_ov",  32'(outValid), 32'(tbl[i].ov));
      check("tbl_od",  32'(outData),  32'(tbl[i].od));
      check("tbl_cnt", 32'(count),    32'(tbl[i].cnt));
      check("tbl_clr", 32'(bufCLR),   32'(tbl[i].clr));
      advance();
    end

    // Full: push refused while full even with a simultaneous pop.
    cycle(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 16'h4000 + 16'(i));
    drive(0, 0, 0, 1, 1, 16'hDEAD);
    check("full_ir",  32'(inReady), 32'h0);
    check("full_cnt", 32'(count),   32'h4);
    advance();
    drive(0, 0, 0, 0, 0, '0);
    check("full_rise", 32'(inReady), 32'h1);
    check("full_cnt3", 32'(count),   32'h3);
    advance();
    for (int i = 1; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, '0);
      check("full_order", 32'(outData), 32'h4000 + 32'(i));
      advance();
    end

    // Continuous push+pop, pointers wrap with count held at 1.
    cycle(0, 0, 0, 1, 0, 16'h5000);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1, 1, 16'h5001 + 16'(i));
      check("stream_cnt", 32'(count),   32'h1);
      check("stream_od",  32'(outData), 32'h5000 + 32'(i));
      advance();
    end
    cycle(0, 0, 0, 0, 1, '0);
    check("stream_err", 32'(err), 32'h0);

    // Abort with three stored words.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 16'h6000 + 16'(i));
    cycle(0, 0, 1, 0, 0, '0);
    drive(0, 0, 0, 0, 0, '0);
    check("abort_clr", 32'(bufCLR),   32'hF);
    check("abort_cnt", 32'(count),    32'h0);
    check("abort_ov",  32'(outValid), 32'h0);
    advance();
    cycle(1, 0, 0, 0, 0, '0);

    // Head buffer reports empty while a word is stored: sticky err.
    cycle(0, 0, 0, 1, 0, 16'h7000);
    kill = 4'b0001;
    cycle(0, 0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, 0, '0);
    check("err_set", 32'(err), 32'h1);
    advance();
    kill = '0;
    drive(0, 0, 0, 0, 0, '0);
    check("err_sticky", 32'(err), 32'h1);
    advance();
    cycle(0, 0, 1, 0, 0, '0);
    drive(0, 0, 0, 0, 0, '0);
    check("err_abort", 32'(err), 32'h0);
    advance();

    // Asynchronous reset in the middle of RUN.
    cycle(1, 0, 0, 0, 0, '0);
    cycle(0, 0, 0, 1, 0, 16'h8000);
    cycle(0, 0, 0, 1, 0, 16'h8001);
    Rst = 1'b1;
    #2;
    check("arst_clr",   32'(bufCLR),   32'hF);
    check("arst_ready", 32'(inReady),  32'h0);
    check("arst_ov",    32'(outValid), 32'h0);
    check("arst_cnt",   32'(count),    32'h0);
    check("arst_en",    32'(bufEN),    32'h0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    model_reset();

    // Randomised traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      bit s, f, a, iv, orr;
      s   = (m_st == M_IDLE) ? ($urandom % 2 == 0) : ($urandom % 8 == 0);
      f   = ($urandom % 25 == 0);
      a   = ($urandom % 80 == 0);
      iv  = ($urandom % 4 != 0);
      orr = ($urandom % 3 != 0);
      cycle(s, f, a, iv, orr, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
